// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: opcodes, predictor sizing and FSM states shared by the fetch unit.
package fetch_ctrl_pkg;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam int         BHT_SIZE    = 16;
    localparam int         BHT_IDX_BIT = 4;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_DROP,
        S_JALR
    } state_t;
endpackage

// File: rtl/bht.sv
// bht: table of 2-bit saturating branch counters, combinational read, registered update.
module bht
    import fetch_ctrl_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [BHT_IDX_BIT-1:0] rd_idx,
    output logic                   rd_taken,
    input  logic                   upd_en,
    input  logic [BHT_IDX_BIT-1:0] upd_idx,
    input  logic                   upd_taken
);
    logic [1:0] ctr [BHT_SIZE];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_SIZE; i++) ctr[i] <= 2'b01;
        end else if (upd_en) begin
            if (upd_taken && ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
            else if (!upd_taken && ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
        end
    end

    // read sees the pre-update value when the same entry is written this cycle
    assign rd_taken = ctr[rd_idx][1];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM feeding the decoder,
// with redirect handling and a bht-based taken prediction per fetched word.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_valid,
    input  logic [31:0] icache_data,
    output logic        to_decoder,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        predict,
    input  logic        dec_accept,
    input  logic [31:0] dec_next_pc,
    input  logic        rob_clear,
    input  logic [31:0] rob_target_pc,
    input  logic        br_update_en,
    input  logic [31:0] br_update_pc,
    input  logic        br_taken
);
    state_t      state, state_nx;
    logic [31:0] pc_nx, inst_nx;
    logic        predict_nx;
    logic        held;
    logic [31:0] held_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        bht_taken;
    logic        outstanding;
    logic        unused_pc_bits;

    // the icache keeps running while paused, so a response seen then is parked here
    assign resp_valid  = icache_valid | held;
    assign resp_data   = held ? held_data : icache_data;
    assign outstanding = state == S_REQ || ((state == S_WAIT || state == S_DROP) && !resp_valid);

    assign icache_req  = state == S_REQ && rdy_in && rst_in;
    assign icache_addr = pc;
    assign to_decoder  = state == S_ISSUE;

    assign unused_pc_bits = ^{br_update_pc[31:BHT_IDX_BIT+2], br_update_pc[1:0]};

    bht u_bht (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rd_idx    (pc[BHT_IDX_BIT+1:2]),
        .rd_taken  (bht_taken),
        .upd_en    (br_update_en && rdy_in),
        .upd_idx   (br_update_pc[BHT_IDX_BIT+1:2]),
        .upd_taken (br_taken)
    );

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        inst_nx    = inst;
        predict_nx = predict;
        if (rdy_in) begin
            if (rob_clear) begin
                pc_nx    = rob_target_pc;
                state_nx = outstanding ? S_DROP : S_REQ;
            end else begin
                case (state)
                    S_REQ: state_nx = S_WAIT;
                    S_WAIT: if (resp_valid) begin
                        inst_nx    = resp_data;
                        predict_nx = bht_taken;
                        state_nx   = S_ISSUE;
                    end
                    S_ISSUE: if (dec_accept) begin
                        state_nx = inst[6:0] == OP_JALR ? S_JALR : S_REQ;
                        pc_nx    = inst[6:0] == OP_JALR ? pc : dec_next_pc;
                    end
                    S_DROP: state_nx = resp_valid ? S_REQ : S_DROP;
                    default: state_nx = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_REQ;
            pc        <= '0;
            inst      <= '0;
            predict   <= 1'b0;
            held      <= 1'b0;
            held_data <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            inst    <= inst_nx;
            predict <= predict_nx;
            if (!rdy_in && icache_valid) begin
                held      <= 1'b1;
                held_data <= icache_data;
            end else if (rdy_in) begin
                held <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed table, hand-written corner sequences and a randomized
// run against a transaction-level model of the fetch unit.
module tb_fetch_ctrl;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk, rst_in, rdy_in;
    logic        icache_req, icache_valid, to_decoder, predict;
    logic [31:0] icache_addr, icache_data, pc, inst;
    logic        dec_accept, rob_clear, br_update_en, br_taken;
    logic [31:0] dec_next_pc, rob_target_pc, br_update_pc;

    int vecs = 0;
    int errs = 0;

    fetch_ctrl dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_valid  (icache_valid),
        .icache_data   (icache_data),
        .to_decoder    (to_decoder),
        .pc            (pc),
        .inst          (inst),
        .predict       (predict),
        .dec_accept    (dec_accept),
        .dec_next_pc   (dec_next_pc),
        .rob_clear     (rob_clear),
        .rob_target_pc (rob_target_pc),
        .br_update_en  (br_update_en),
        .br_update_pc  (br_update_pc),
        .br_taken      (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, iv;
        logic [31:0] idata;
        logic        acc;
        logic [31:0] nxt;
        logic        clr;
        logic [31:0] tgt;
        logic        e_req, e_tod;
        logic [31:0] e_pc, e_inst;
        logic        e_pred;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(logic rdy, logic iv, logic [31:0] idata, logic acc, logic [31:0] nxt,
                                logic clr, logic [31:0] tgt, logic e_req, logic e_tod,
                                logic [31:0] e_pc, logic [31:0] e_inst, logic e_pred);
        vec_t v;
        v.rdy = rdy; v.iv = iv; v.idata = idata; v.acc = acc; v.nxt = nxt; v.clr = clr; v.tgt = tgt;
        v.e_req = e_req; v.e_tod = e_tod; v.e_pc = e_pc; v.e_inst = e_inst; v.e_pred = e_pred;
        return v;
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] h;
        h = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        return (a[4:2] == 3'd5) ? {h[31:7], 7'b1100111} : {h[31:7], 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; icache_valid = 1'b0; icache_data = '0; dec_accept = 1'b0; dec_next_pc = '0;
        rob_clear = 1'b0; rob_target_pc = '0; br_update_en = 1'b0; br_update_pc = '0; br_taken = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(icache_req), 32'(0));
        chk("rst_tod", 32'(to_decoder), 32'(0));
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pred", 32'(predict), 32'(0));
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    task automatic upd(input int n, input logic [31:0] a, input logic t);
        repeat (n) begin
            br_update_en = 1'b1; br_update_pc = a; br_taken = t;
            @(negedge clk);
        end
        br_update_en = 1'b0;
    endtask

    // accept the word in ISSUE and fetch a non-jalr word at a, optionally updating its counter in the latch cycle
    task automatic fetch_at(input logic [31:0] a, input logic e_pred, input logic same_upd);
        dec_accept = 1'b1; dec_next_pc = a;
        #1 chk("fa_tod_pre", 32'(to_decoder), 32'(1));
        @(negedge clk);
        dec_accept = 1'b0;
        #1 chk("fa_req", 32'(icache_req), 32'(1));
        chk("fa_addr", icache_addr, a);
        @(negedge clk);
        icache_valid = 1'b1; icache_data = 32'h13;
        br_update_en = same_upd; br_update_pc = a; br_taken = 1'b1;
        @(negedge clk);
        icache_valid = 1'b0; br_update_en = 1'b0;
        #1 chk("fa_tod", 32'(to_decoder), 32'(1));
        chk("fa_pc", pc, a);
        chk("fa_pred", 32'(predict), 32'(e_pred));
    endtask

    int          ctr [16];
    logic [31:0] m_pc, rword, w;
    logic        m_out, m_stale, m_have, m_jalr, m_pred, resp, fresh, have0;
    int          cnt;

    initial begin
        tbl[0]  = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   H, L, 32'h0,   32'h0,        L);
        tbl[1]  = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   L, L, 32'h0,   32'h0,        L);
        tbl[2]  = mk(H, H, 32'h13,       L, 32'h0,  L, 32'h0,   L, L, 32'h0,   32'h0,        L);
        for (int i = 3; i < 8; i++)
            tbl[i] = mk(H, L, 32'h0,     L, 32'h0,  L, 32'h0,   L, H, 32'h0,   32'h13,       L);
        tbl[8]  = mk(H, L, 32'h0,        H, 32'h8,  L, 32'h0,   L, H, 32'h0,   32'h13,       L);
        tbl[9]  = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   H, L, 32'h8,   32'h0,        L);
        tbl[10] = mk(H, H, 32'h80E7,     L, 32'h0,  L, 32'h0,   L, L, 32'h8,   32'h0,        L);
        tbl[11] = mk(H, L, 32'h0,        H, 32'h44, L, 32'h0,   L, H, 32'h8,   32'h80E7,     L);
        tbl[12] = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   L, L, 32'h8,   32'h0,        L);
        tbl[13] = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   L, L, 32'h8,   32'h0,        L);
        tbl[14] = mk(H, L, 32'h0,        L, 32'h0,  H, 32'h100, L, L, 32'h8,   32'h0,        L);
        tbl[15] = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   H, L, 32'h100, 32'h0,        L);
        tbl[16] = mk(H, L, 32'h0,        L, 32'h0,  H, 32'h40,  L, L, 32'h100, 32'h0,        L);
        tbl[17] = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   L, L, 32'h40,  32'h0,        L);
        tbl[18] = mk(H, H, 32'hDEAD0013, L, 32'h0,  L, 32'h0,   L, L, 32'h40,  32'h0,        L);
        tbl[19] = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   H, L, 32'h40,  32'h0,        L);
        tbl[20] = mk(H, H, 32'h00400093, L, 32'h0,  L, 32'h0,   L, L, 32'h40,  32'h0,        L);
        tbl[21] = mk(H, L, 32'h0,        L, 32'h0,  L, 32'h0,   L, H, 32'h40,  32'h00400093, L);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            rdy_in = tbl[i].rdy; icache_valid = tbl[i].iv; icache_data = tbl[i].idata;
            dec_accept = tbl[i].acc; dec_next_pc = tbl[i].nxt;
            rob_clear = tbl[i].clr; rob_target_pc = tbl[i].tgt;
            #1;
            chk($sformatf("row%0d_req", i), 32'(icache_req), 32'(tbl[i].e_req));
            chk($sformatf("row%0d_tod", i), 32'(to_decoder), 32'(tbl[i].e_tod));
            chk($sformatf("row%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("row%0d_addr", i), icache_addr, tbl[i].e_pc);
            if (tbl[i].e_tod) begin
                chk($sformatf("row%0d_inst", i), inst, tbl[i].e_inst);
                chk($sformatf("row%0d_pred", i), 32'(predict), 32'(tbl[i].e_pred));
            end
            @(negedge clk);
        end
        idle();

        // counter saturation in both directions and same-cycle update/read
        upd(4, 32'h10, 1'b1);
        fetch_at(32'h10, 1'b1, 1'b0);
        upd(2, 32'h10, 1'b0);
        fetch_at(32'h10, 1'b0, 1'b1);
        fetch_at(32'h10, 1'b1, 1'b0);
        upd(4, 32'h10, 1'b0);
        upd(1, 32'h10, 1'b1);
        fetch_at(32'h10, 1'b0, 1'b0);

        // pause during ISSUE with accept held high; table updates must also be frozen
        rdy_in = 1'b0; dec_accept = 1'b1; dec_next_pc = 32'h20;
        br_update_en = 1'b1; br_update_pc = 32'h20; br_taken = 1'b1;
        repeat (3) begin
            #1;
            chk("pause_tod", 32'(to_decoder), 32'(1));
            chk("pause_req", 32'(icache_req), 32'(0));
            chk("pause_pc", pc, 32'h10);
            chk("pause_inst", inst, 32'h13);
            @(negedge clk);
        end
        rdy_in = 1'b1; br_update_en = 1'b0;
        #1 chk("unpause_tod", 32'(to_decoder), 32'(1));
        @(negedge clk);
        dec_accept = 1'b0;
        #1 chk("unpause_req", 32'(icache_req), 32'(1));
        chk("unpause_addr", icache_addr, 32'h20);
        @(negedge clk);
        rdy_in = 1'b0; icache_valid = 1'b1; icache_data = 32'h13;
        @(negedge clk);
        icache_valid = 1'b0;
        #1 chk("held_tod0", 32'(to_decoder), 32'(0));
        @(negedge clk);
        rdy_in = 1'b1;
        #1 chk("held_tod1", 32'(to_decoder), 32'(0));
        @(negedge clk);
        #1 chk("held_tod2", 32'(to_decoder), 32'(1));
        chk("held_inst", inst, 32'h13);
        chk("held_pred", 32'(predict), 32'(0));

        // reset while a request is outstanding
        dec_accept = 1'b1; dec_next_pc = 32'h30;
        @(negedge clk);
        dec_accept = 1'b0;
        #1 chk("mid_req", 32'(icache_req), 32'(1));
        chk("mid_addr", icache_addr, 32'h30);
        @(negedge clk);
        rst_in = 1'b0;
        #1 chk("mid_rst_req", 32'(icache_req), 32'(0));
        chk("mid_rst_tod", 32'(to_decoder), 32'(0));
        chk("mid_rst_pc", pc, 32'h0);
        @(negedge clk);
        rst_in = 1'b1;
        #1 chk("mid_rel_req", 32'(icache_req), 32'(1));
        chk("mid_rel_addr", icache_addr, 32'h0);

        // randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) ctr[i] = 1;
        m_pc = '0; m_out = 0; m_stale = 0; m_have = 0; m_jalr = 0; m_pred = 0; cnt = 0; rword = '0;
        for (int c = 0; c < 3000; c++) begin
            idle();
            icache_valid  = (cnt == 1);
            icache_data   = rword;
            dec_accept    = ($urandom_range(0, 2) == 0);
            dec_next_pc   = 32'($urandom_range(0, 63)) << 2;
            rob_clear     = m_jalr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
            rob_target_pc = 32'($urandom_range(0, 63)) << 2;
            br_update_en  = ($urandom_range(0, 1) == 1);
            br_update_pc  = 32'($urandom_range(0, 63)) << 2;
            br_taken      = ($urandom_range(0, 1) == 1);
            #1;
            chk("rnd_req", 32'(icache_req), 32'(!m_out && !m_have && !m_jalr));
            if (icache_req) chk("rnd_addr", icache_addr, m_pc);
            chk("rnd_tod", 32'(to_decoder), 32'(m_have));
            if (m_have) begin
                chk("rnd_pc", pc, m_pc);
                chk("rnd_inst", inst, mem(m_pc));
                chk("rnd_pred", 32'(predict), 32'(m_pred));
            end
            resp = (cnt == 1);
            if (cnt > 0) cnt--;
            fresh = resp && !m_stale && !rob_clear;
            have0 = m_have;
            if (resp) begin m_out = 0; m_stale = 0; end
            if (fresh) begin m_have = 1; m_pred = (ctr[m_pc[5:2]] >= 2); end
            if (rob_clear) begin
                m_pc = rob_target_pc; m_have = 0; m_jalr = 0;
                if (m_out) m_stale = 1;
            end else if (have0 && dec_accept) begin
                m_have = 0;
                w = mem(m_pc);
                if (w[6:0] == 7'b1100111) m_jalr = 1;
                else m_pc = dec_next_pc;
            end
            if (icache_req) begin
                m_out = 1; m_stale = rob_clear;
                cnt = $urandom_range(1, 3);
                rword = mem(icache_addr);
            end
            if (br_update_en) begin
                if (br_taken) ctr[br_update_pc[5:2]] = (ctr[br_update_pc[5:2]] == 3) ? 3 : ctr[br_update_pc[5:2]] + 1;
                else ctr[br_update_pc[5:2]] = (ctr[br_update_pc[5:2]] == 0) ? 0 : ctr[br_update_pc[5:2]] - 1;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
